// File: rtl/two_high_if.sv
// Signal bundle for the two_high run detector: serial sample in, qualified level out.
// The master side drives the stream and the slave side (the detector) reports the run.
interface two_high_if;
  logic data_in;
  logic two_out;

  modport master (
    output data_in,
    input  two_out
  );

  modport slave (
    input  data_in,
    output two_out
  );
endinterface

// File: rtl/two_high.sv
// Run detector: two_out is high once data_in has been sampled high on the last RUN_LEN edges.
// Output is decoded from registered history only, so there is no data_in-to-two_out path.
module two_high #(
  parameter int unsigned RUN_LEN = 2
) (
  input  logic clk,
  input  logic data_in,
  output logic two_out,
  input  logic reset
);

  typedef logic [RUN_LEN-1:0] hist_t;

  hist_t hist_q;
  hist_t hist_d;

  // hist_q[0] is the newest sample; the cast keeps this legal for RUN_LEN == 1.
  always_comb begin
    hist_d = (hist_q << 1) | hist_t'(data_in);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q <= '0;
    end else begin
      hist_q <= hist_d;
    end
  end

  assign two_out = &hist_q;

endmodule

// File: tb/tb_two_high.sv
// Scoreboard bench for two_high at RUN_LEN = 1, 2 and 3 driven by one shared stream.
// A run-length counter model predicts each output; a negedge monitor pops and compares.
module tb_two_high;

  logic clk;
  logic reset;
  logic out1;
  logic out3;

  two_high_if bus ();

  two_high #(.RUN_LEN(2)) u_dut2 (
    .clk     (clk),
    .data_in (bus.data_in),
    .two_out (bus.two_out),
    .reset   (reset)
  );

  two_high #(.RUN_LEN(1)) u_dut1 (
    .clk     (clk),
    .data_in (bus.data_in),
    .two_out (out1),
    .reset   (reset)
  );

  two_high #(.RUN_LEN(3)) u_dut3 (
    .clk     (clk),
    .data_in (bus.data_in),
    .two_out (out3),
    .reset   (reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic  e1;
    logic  e2;
    logic  e3;
    string tag;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   run    = 0;  // consecutive high samples since the last low or reset

  // Apply one sample, let the edge happen, then queue what every instance must show.
  task automatic step(input logic d, input logic r, input string tag);
    exp_t e;
    bus.data_in = d;
    reset       = r;
    @(posedge clk);
    if (r)      run = 0;
    else if (d) run = (run < 64) ? run + 1 : run;
    else        run = 0;
    e.e1  = (run >= 1);
    e.e2  = (run >= 2);
    e.e3  = (run >= 3);
    e.tag = tag;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks = checks + 1;
      if (bus.two_out !== e.e2 || out1 !== e.e1 || out3 !== e.e3) begin
        errors = errors + 1;
        $display("FAIL %s: got L1=%b L2=%b L3=%b, want L1=%b L2=%b L3=%b",
                 e.tag, out1, bus.two_out, out3, e.e1, e.e2, e.e3);
      end
    end
  end

  initial begin
    bus.data_in = 1'b0;
    reset       = 1'b1;
    @(negedge clk);

    step(1'b1, 1'b1, "reset_hold_high");
    step(1'b0, 1'b1, "reset_state");

    step(1'b0, 1'b0, "idle_low0");
    step(1'b0, 1'b0, "idle_low1");

    step(1'b1, 1'b0, "rise_edge1");
    step(1'b1, 1'b0, "rise_edge2");
    step(1'b1, 1'b0, "rise_edge3");
    step(1'b1, 1'b0, "rise_edge4");
    step(1'b0, 1'b0, "fall");

    step(1'b0, 1'b0, "glitch0");
    step(1'b1, 1'b0, "glitch1");
    step(1'b0, 1'b0, "glitch2");
    step(1'b1, 1'b0, "glitch3");
    step(1'b0, 1'b0, "glitch4");

    step(1'b1, 1'b0, "pre_reset1");
    step(1'b1, 1'b0, "pre_reset2");
    step(1'b1, 1'b0, "pre_reset3");
    step(1'b1, 1'b1, "reset_mid_run");
    step(1'b1, 1'b0, "post_reset1");
    step(1'b1, 1'b0, "post_reset2");
    step(1'b1, 1'b0, "post_reset3");

    for (int i = 0; i < 400; i++) begin
      logic d;
      logic r;
      d = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 31) == 0);
      step(d, r, "random");
    end

    step(1'b0, 1'b0, "drain");
    @(negedge clk);
    @(negedge clk);
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/two_high.md
Name: two_high

Overview:
- Run detector for one serial bit stream.
- two_out asserts when data_in has been sampled high on the RUN_LEN most recent rising clock edges (default 2).
- Sits in control paths that need a debounced or confirmed-high qualifier.
- Fully synchronous, single clock domain.

Parameters:
- RUN_LEN, default 2: number of consecutive high samples required before two_out asserts. Legal range is 1 to 32.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- data_in  input  1  serial input, sampled on each clk rising edge.
- two_out  output  1  high while the last RUN_LEN samples of data_in were all 1.
- Declaration order is clk, data_in, two_out, reset. Existing positional instantiations use the first three ports. If reset is left unconnected (z), the block operates unreset.

Behaviour:
- State: a RUN_LEN-bit shift register hist.
  - On each clk rising edge, hist shifts in data_in. hist[0] is the newest sample.
- two_out is the AND of all hist bits. It is a combinational function of registered state only, with no combinational path from data_in.
- Reset:
  - When reset is 1 at a rising edge, hist clears to all 0, so two_out = 0 on the following cycle.
  - Reset has priority over the data_in shift.
  - Reset mid-run discards the run. After reset deasserts, RUN_LEN new high samples are needed again.
- Latency with RUN_LEN=2:
  - data_in rises before edge N.
  - After edge N: two_out = 0.
  - After edge N+1: two_out = 1.
  - two_out stays 1 while data_in stays 1.
- Deassertion: if data_in is 0 at edge M, two_out = 0 immediately after edge M (one-edge latency).
- Isolated pulse: a single-cycle high on data_in (surrounded by 0) never asserts two_out when RUN_LEN is 2 or more.
- Power-up without reset:
  - two_out may be X until RUN_LEN edges have been clocked.
  - After RUN_LEN low samples of data_in, two_out must be 0.
- RUN_LEN=1: two_out is a registered copy of data_in.
- No handshake, no enable; every rising edge samples data_in.

Test Plan:
- Idle low: reset=0, data_in=0 for 2 edges -> two_out=0.
- Rise (RUN_LEN=2): set data_in=1 -> two_out=0 after the first edge, two_out=1 after the second edge, and still 1 after the third edge.
- Fall: data_in=1 steady with two_out=1, then data_in=0 -> two_out=0 after the next edge.
- Glitch rejection: data_in pattern 0,1,0,1,0 across edges -> two_out=0 throughout.
- Reset mid-run: data_in=1 with two_out=1; assert reset for 1 edge while data_in=1 -> two_out=0 after that edge. Deassert reset -> two_out=0 after the first following edge, then 1 after the second.
- Parameter sweep RUN_LEN=3: data_in=1 held -> two_out=0 after edges 1 and 2, and 1 after edge 3.
